// File: rtl/serial_bus_pkg.sv
// Shared constants for the serial slave port: FSM state encodings, status/rw codes, line levels.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_bus_pkg;

  // FSM state encodings (SPLIT_WAIT is only reachable when split support is built in)
  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_RX_RW      = 4'd1;
  localparam logic [3:0] ST_RX_ADDR    = 4'd2;
  localparam logic [3:0] ST_RX_DATA    = 4'd3;
  localparam logic [3:0] ST_EXEC       = 4'd4;
  localparam logic [3:0] ST_SPLIT_WAIT = 4'd5;
  localparam logic [3:0] ST_TX_START   = 4'd6;
  localparam logic [3:0] ST_TX_STATUS  = 4'd7;
  localparam logic [3:0] ST_TX_DATA    = 4'd8;

  localparam logic STATUS_OK    = 1'b0;
  localparam logic STATUS_SPLIT = 1'b1;
  localparam logic RW_READ      = 1'b0;
  localparam logic RW_WRITE     = 1'b1;
  localparam logic START_BIT    = 1'b0;
  localparam logic IDLE_BIT     = 1'b1;

  // Larger of two widths, used to size the shared rx bit counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Loadable LSB-first shift register with a count of bits shifted out since the last load.
// Latency: load takes effect next clk; lsb always shows the next bit to send.
// Backpressure: none; shifts only when the owner asserts shift.
module bit_serializer #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [W-1:0]     load_dat,
  input  logic             shift,
  output logic             lsb,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0] shreg;

  // Load restarts the count; each shift drops the LSB and counts it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg <= '0;
      count <= '0;
    end else if (load) begin
      shreg <= load_dat;
      count <= '0;
    end else if (shift) begin
      shreg <= shreg >> 1;
      count <= count + CNT_W'(1);
    end
  end

  assign lsb = shreg[0];

endmodule

// File: rtl/serial_slave_port.sv
// Serial slave: deserialises request frames on rx, executes against local memory, replies on tx.
// Latency: response start bit appears 2 clks after the last request bit; one bit per clk after that.
// Backpressure: ready=1 only in IDLE; optional busy input (macro SLV_SPLIT_EN) forces SPLIT replies.
module serial_slave_port
  import serial_bus_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx,
  output logic ready
`ifdef SLV_SPLIT_EN
  ,
  input  logic busy
`endif
);

  localparam int ADDR_W   = $clog2(MEM_DEPTH);
  localparam int RX_CNT_W = $clog2(max_int(ADDR_W, DATA_W) + 1);
  localparam int TX_CNT_W = $clog2(DATA_W + 1);

  logic [3:0]          state, state_nxt;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [RX_CNT_W-1:0] rx_cnt;
  logic                status_q;
  logic                exec_split;
  logic                exec_ok;
  logic                ser_load;
  logic                ser_shift;
  logic                ser_lsb;
  logic [TX_CNT_W-1:0] tx_cnt;
  logic                tx_d;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

`ifdef SLV_SPLIT_EN
  assign exec_split = (state == ST_EXEC) && busy;
`else
  assign exec_split = 1'b0;
`endif
  assign exec_ok = (state == ST_EXEC) && !exec_split;

  // Next-state decode; rx is only looked at in IDLE and the RX_* states
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (rx == START_BIT) state_nxt = ST_RX_RW;
      ST_RX_RW:     state_nxt = ST_RX_ADDR;
      ST_RX_ADDR:   if (rx_cnt == RX_CNT_W'(ADDR_W - 1))
                      state_nxt = (rw_q == RW_WRITE) ? ST_RX_DATA : ST_EXEC;
      ST_RX_DATA:   if (rx_cnt == RX_CNT_W'(DATA_W - 1)) state_nxt = ST_EXEC;
      ST_EXEC:      state_nxt = ST_TX_START;
      ST_TX_START:  state_nxt = ST_TX_STATUS;
      ST_TX_STATUS: begin
        if (rw_q == RW_READ) state_nxt = ST_TX_DATA;
        else                 state_nxt = ST_IDLE;
`ifdef SLV_SPLIT_EN
        // A split reply carries no data; park until busy drops
        if (status_q == STATUS_SPLIT) state_nxt = ST_SPLIT_WAIT;
`endif
      end
      ST_TX_DATA:   if (tx_cnt == TX_CNT_W'(DATA_W)) state_nxt = ST_IDLE;
`ifdef SLV_SPLIT_EN
      ST_SPLIT_WAIT: if (!busy) state_nxt = ST_EXEC;
`endif
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Request deserialiser: rw, then addr and data LSB first; fields hold through EXEC/SPLIT_WAIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rw_q   <= RW_READ;
      addr_q <= '0;
      data_q <= '0;
      rx_cnt <= '0;
    end else begin
      if (state == ST_RX_RW)   rw_q   <= rx;
      if (state == ST_RX_ADDR) addr_q <= {rx, addr_q[ADDR_W-1:1]};
      if (state == ST_RX_DATA) data_q <= {rx, data_q[DATA_W-1:1]};
      if ((state == ST_RX_ADDR || state == ST_RX_DATA) && state_nxt == state)
        rx_cnt <= rx_cnt + RX_CNT_W'(1);
      else
        rx_cnt <= '0;
    end
  end

  // Status of the reply being built, decided in EXEC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 status_q <= STATUS_OK;
    else if (state == ST_EXEC) status_q <= exec_split ? STATUS_SPLIT : STATUS_OK;
  end

  // Register memory; writes land in EXEC so a following read sees them
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (exec_ok && rw_q == RW_WRITE) begin
      mem[addr_q] <= data_q;
    end
  end

  assign ser_load  = exec_ok && (rw_q == RW_READ);
  assign ser_shift = (state_nxt == ST_TX_DATA);

  bit_serializer #(
    .W     (DATA_W),
    .CNT_W (TX_CNT_W)
  ) u_tx_ser (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ser_load),
    .load_dat (mem[addr_q]),
    .shift    (ser_shift),
    .lsb      (ser_lsb),
    .count    (tx_cnt)
  );

  // tx level for the state being entered, so the line is a clean flop output
  always_comb begin
    tx_d = IDLE_BIT;
    case (state_nxt)
      ST_TX_START:  tx_d = START_BIT;
      ST_TX_STATUS: tx_d = status_q;
      ST_TX_DATA:   tx_d = ser_lsb;
      default:      tx_d = IDLE_BIT;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx    <= IDLE_BIT;
      ready <= 1'b1;
    end else begin
      tx    <= tx_d;
      ready <= (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
`timescale 1ns/1ps
module tb_serial_slave_port;

  typedef struct {
    logic       status;
    bit         has_data;
    logic [7:0] data;
    int         start_cyc;   // -1: start time not checked
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic rx = 1'b1;
  logic tx;
  logic ready;
`ifdef SLV_SPLIT_EN
  logic busy = 1'b0;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_cyc = 0;
  bit   mon_busy = 1'b0;
  exp_t sb[$];

  serial_slave_port #(.DATA_W(8), .MEM_DEPTH(16)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rx    (rx),
    .tx    (tx),
    .ready (ready)
`ifdef SLV_SPLIT_EN
    ,
    .busy  (busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic status, input bit has_data, input logic [7:0] data,
                          input int start_cyc);
    exp_t e;
    e.status = status; e.has_data = has_data; e.data = data; e.start_cyc = start_cyc;
    sb.push_back(e);
  endtask

  // Drive one request frame; expectation is queued as soon as the last bit is on the line
  task automatic send(input logic rw, input logic [3:0] addr, input logic [7:0] wdat,
                      input logic exp_status, input logic [7:0] exp_data);
    logic [13:0] f;
    int n;
    f = {wdat, addr, rw, 1'b0};
    n = rw ? 14 : 6;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = f[i];
    end
    last_cyc = cyc;
    push_exp(exp_status, (rw == 1'b0) && (exp_status == 1'b0), exp_data, last_cyc + 2);
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((sb.size() != 0 || mon_busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++; errors++;
      $display("FAIL wait_done: timeout with %0d responses outstanding", sb.size());
    end
    @(negedge clk);
  endtask

  // Monitor: decode every response frame on tx and compare with the queue head
  initial begin
    exp_t e;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_response: start bit at cycle %0d, none required", cyc);
        end else begin
          mon_busy = 1'b1;
          e = sb.pop_front();
          if (e.start_cyc >= 0) check("start_latency", cyc, e.start_cyc);
          @(negedge clk);
          check("status", {31'd0, tx}, {31'd0, e.status});
          if (e.has_data) begin
            d = '0;
            for (int i = 0; i < 8; i++) begin
              @(negedge clk);
              d[i] = tx;
            end
            check("rd_data", {24'd0, d}, {24'd0, e.data});
          end
          @(negedge clk);
          check("tx_idle_after", {31'd0, tx}, 32'd1);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then read of untouched memory
    #1ns rstn = 1'b0;
    #1ps rstn = 1'b1;
    #1ps;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, ready}, 32'd1);
    send(1'b0, 4'd5, 8'h00, 1'b0, 8'h00);
    wait_done();

    // 2: write then read back
    send(1'b1, 4'd3, 8'hA5, 1'b0, 8'h00);
    wait_done();
    send(1'b0, 4'd3, 8'h00, 1'b0, 8'hA5);
    wait_done();

    // 3: back-to-back write/read on the top address
    send(1'b1, 4'd15, 8'h3C, 1'b0, 8'h00);
    wait_done();
    send(1'b0, 4'd15, 8'h00, 1'b0, 8'h3C);
    wait_done();

    // 4: reset during the data field of a write: no reply, memory cleared
    for (int i = 0; i < 9; i++) begin
      logic [13:0] f;
      f = {8'hFF, 4'd1, 1'b1, 1'b0};
      @(negedge clk);
      rx = f[i];
    end
    #2ns rstn = 1'b0;
    #1ps rstn = 1'b1;
    rx = 1'b1;
    #1ps;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_ready", {31'd0, ready}, 32'd1);
    repeat (25) @(negedge clk);
    send(1'b0, 4'd1, 8'h00, 1'b0, 8'h00);
    wait_done();
    send(1'b0, 4'd3, 8'h00, 1'b0, 8'h00);
    wait_done();

`ifdef SLV_SPLIT_EN
    // 5: split transaction on a read of addr 2
    send(1'b1, 4'd2, 8'h11, 1'b0, 8'h00);
    wait_done();
    busy = 1'b1;
    send(1'b0, 4'd2, 8'h00, 1'b1, 8'h00);
    push_exp(1'b0, 1'b1, 8'h11, -1);
    repeat (6) @(negedge clk);
    check("split_ready_low", {31'd0, ready}, 32'd0);
    #1000ps busy = 1'b0;
    wait_done();
    check("split_ready_after", {31'd0, ready}, 32'd1);
`endif

    // 6: start bit during TX_DATA must be ignored
    send(1'b1, 4'd7, 8'h5A, 1'b0, 8'h00);
    wait_done();
    send(1'b0, 4'd7, 8'h00, 1'b0, 8'h5A);
    while (cyc < last_cyc + 6) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    wait_done();
    repeat (30) @(negedge clk);
    check("no_extra_response", sb.size(), 32'd0);
    check("final_ready", {31'd0, ready}, 32'd1);
    check("final_tx", {31'd0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
